// File: rtl/eth_tx_arbiter_pkg.sv
// rtl/eth_tx_arbiter_pkg.sv - shared widths, FSM state type and source-pick helpers for eth_tx_arbiter
package eth_tx_arb_pkg;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_KEEP_W = 4;
    localparam int FRAME_CNT_W = 16;
    localparam int MAX_SRC     = 4;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } arb_state_e;

    typedef logic [1:0] src_idx_t;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] tdata;
        logic [AXIS_KEEP_W-1:0] tkeep;
        logic                   tlast;
    } axis_beat_t;

    // First requester strictly after ptr, wrapping; ptr itself is checked last.
    function automatic src_idx_t rr_pick(input logic [MAX_SRC-1:0] req, input src_idx_t ptr, input int n);
        int s;
        rr_pick = ptr;
        for (int i = MAX_SRC; i >= 1; i--) begin
            s = int'(ptr) + i;
            if (s >= n) begin
                s = s - n;
            end
            if (i <= n && req[s[1:0]]) begin
                rr_pick = src_idx_t'(s);
            end
        end
    endfunction

    function automatic src_idx_t prio_pick(input logic [MAX_SRC-1:0] req, input int n);
        prio_pick = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (i < n && req[i]) begin
                prio_pick = src_idx_t'(i);
            end
        end
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// rtl/eth_tx_arbiter_if.sv - single-lane AXIS stream bundle used between arbiter stages and toward the MAC
interface eth_tx_arbiter_if;
    import eth_tx_arb_pkg::*;

    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic                   tvalid;
    logic                   tlast;
    logic                   tready;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/eth_tx_arbiter_skid_buffer.sv
// rtl/eth_tx_arbiter_skid_buffer.sv - two-entry registered AXIS skid buffer (data, keep, last)
module axis_skid_buffer
    import eth_tx_arb_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset_n,
    eth_tx_arbiter_if.slave  s_axis,
    eth_tx_arbiter_if.master m_axis
);

    axis_beat_t r_out;
    axis_beat_t r_skid;
    logic       r_out_valid;
    logic       r_skid_valid;

    axis_beat_t w_in;
    logic       w_in_acc;
    logic       w_load_out;

    assign w_in       = {s_axis.tdata, s_axis.tkeep, s_axis.tlast};
    // Upstream ready depends only on skid occupancy, so no combinational path from m_axis.tready.
    assign s_axis.tready = ~r_skid_valid;
    assign w_in_acc      = s_axis.tvalid & ~r_skid_valid;
    assign w_load_out    = ~r_out_valid | m_axis.tready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_load_out) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_in_acc;
                if (w_in_acc) begin
                    r_out <= w_in;
                end
            end
        end else if (w_in_acc) begin
            r_skid       <= w_in;
            r_skid_valid <= 1'b1;
        end
    end

    assign m_axis.tdata  = r_out.tdata;
    assign m_axis.tkeep  = r_out.tkeep;
    assign m_axis.tlast  = r_out.tlast;
    assign m_axis.tvalid = r_out_valid;

endmodule

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - frame-granular AXIS arbiter for MAC TX; ETH_TX_ARB_STRICT_PRIO_EN selects fixed priority
module eth_tx_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int OUT_REG = 1
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic [NUM_SRC*AXIS_DATA_W-1:0] s00_axis_tdata,
    input  logic [NUM_SRC*AXIS_KEEP_W-1:0] s00_axis_tkeep,
    input  logic [NUM_SRC-1:0]             s00_axis_tvalid,
    input  logic [NUM_SRC-1:0]             s00_axis_tlast,
    output logic [NUM_SRC-1:0]             s00_axis_tready,
    output logic [AXIS_DATA_W-1:0]         m00_axis_tdata,
    output logic [AXIS_KEEP_W-1:0]         m00_axis_tkeep,
    output logic                           m00_axis_tvalid,
    output logic                           m00_axis_tlast,
    input  logic                           m00_axis_tready,
    output logic [NUM_SRC-1:0]             o_grant,
    output logic [NUM_SRC*FRAME_CNT_W-1:0] o_frame_count
);

    arb_state_e                     r_state;
    arb_state_e                     w_state_nxt;
    logic [NUM_SRC-1:0]             r_grant;
    logic [NUM_SRC-1:0]             w_grant_nxt;
    src_idx_t                       r_gidx;
    src_idx_t                       w_gidx_nxt;
    src_idx_t                       r_rr_ptr;
    src_idx_t                       w_rr_nxt;
    src_idx_t                       w_pick;
    logic [MAX_SRC-1:0]             w_req;
    logic [MAX_SRC-1:0]             w_pick_onehot;
    logic [NUM_SRC*FRAME_CNT_W-1:0] r_frame_count;
    axis_beat_t                     w_mux_beat;
    logic                           w_mux_valid;
    logic                           w_out_ready;
    logic                           w_beat_acc;
    logic                           w_frame_done;

    eth_tx_arbiter_if w_arb_if ();
    eth_tx_arbiter_if w_out_if ();

    assign w_req = MAX_SRC'(s00_axis_tvalid);

`ifdef ETH_TX_ARB_STRICT_PRIO_EN
    assign w_pick = prio_pick(w_req, NUM_SRC);
`else
    assign w_pick = rr_pick(w_req, r_rr_ptr, NUM_SRC);
`endif

    assign w_pick_onehot = MAX_SRC'(1) << w_pick;

    // Grant is one-hot, so OR-ing the selected lane is a plain mux; nothing passes while idle.
    always_comb begin
        w_mux_beat  = '0;
        w_mux_valid = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (r_grant[k]) begin
                w_mux_beat.tdata = s00_axis_tdata[k*AXIS_DATA_W +: AXIS_DATA_W];
                w_mux_beat.tkeep = s00_axis_tkeep[k*AXIS_KEEP_W +: AXIS_KEEP_W];
                w_mux_beat.tlast = s00_axis_tlast[k];
                w_mux_valid      = s00_axis_tvalid[k];
            end
        end
    end

    assign w_beat_acc      = (r_state == PASS) & w_mux_valid & w_out_ready;
    assign s00_axis_tready = (r_state == PASS && w_out_ready) ? r_grant : '0;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= src_idx_t'(NUM_SRC - 1);
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_gidx   <= w_gidx_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_gidx_nxt   = r_gidx;
        w_rr_nxt     = r_rr_ptr;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (|s00_axis_tvalid) begin
                    w_state_nxt = PASS;
                    w_gidx_nxt  = w_pick;
                    w_grant_nxt = w_pick_onehot[NUM_SRC-1:0];
                end
            end
            PASS: begin
                // Grant is only released by an accepted tlast; a silent owner keeps it.
                if (w_beat_acc && w_mux_beat.tlast) begin
                    w_state_nxt  = IDLE;
                    w_grant_nxt  = '0;
                    w_rr_nxt     = r_gidx;
                    w_frame_done = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_frame_count <= '0;
        end else if (w_frame_done) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (r_grant[k]) begin
                    r_frame_count[k*FRAME_CNT_W +: FRAME_CNT_W] <=
                        r_frame_count[k*FRAME_CNT_W +: FRAME_CNT_W] + FRAME_CNT_W'(1);
                end
            end
        end
    end

    assign w_arb_if.tdata  = w_mux_beat.tdata;
    assign w_arb_if.tkeep  = w_mux_beat.tkeep;
    assign w_arb_if.tlast  = w_mux_beat.tlast;
    assign w_arb_if.tvalid = w_mux_valid;
    assign w_out_ready     = w_arb_if.tready;
    assign w_out_if.tready = m00_axis_tready;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            axis_skid_buffer u_skid (
                .i_clk     (i_clk),
                .i_reset_n (i_reset_n),
                .s_axis    (w_arb_if),
                .m_axis    (w_out_if)
            );
        end else begin : g_out_comb
            assign w_out_if.tdata  = w_arb_if.tdata;
            assign w_out_if.tkeep  = w_arb_if.tkeep;
            assign w_out_if.tlast  = w_arb_if.tlast;
            assign w_out_if.tvalid = w_arb_if.tvalid;
            assign w_arb_if.tready = w_out_if.tready;
        end
    endgenerate

    assign m00_axis_tdata  = w_out_if.tdata;
    assign m00_axis_tkeep  = w_out_if.tkeep;
    assign m00_axis_tvalid = w_out_if.tvalid;
    assign m00_axis_tlast  = w_out_if.tlast;
    assign o_grant         = r_grant;
    assign o_frame_count   = r_frame_count;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - directed vector bench for eth_tx_arbiter (NUM_SRC=2, OUT_REG=1, round-robin build)
module tb_eth_tx_arbiter;
    import eth_tx_arb_pkg::*;

    localparam int NS = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NS*32-1:0]  s_tdata;
    logic [NS*4-1:0]   s_tkeep;
    logic [NS-1:0]     s_tvalid;
    logic [NS-1:0]     s_tlast;
    logic [NS-1:0]     s_tready;
    logic [NS-1:0]     grant;
    logic [NS*16-1:0]  fcnt;

    int n_vec = 0;
    int n_err = 0;

    eth_tx_arbiter_if m00_if ();

    always #5 clk = ~clk;

    eth_tx_arbiter #(.NUM_SRC(NS), .OUT_REG(1)) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tkeep  (s_tkeep),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tready (s_tready),
        .m00_axis_tdata  (m00_if.tdata),
        .m00_axis_tkeep  (m00_if.tkeep),
        .m00_axis_tvalid (m00_if.tvalid),
        .m00_axis_tlast  (m00_if.tlast),
        .m00_axis_tready (m00_if.tready),
        .o_grant         (grant),
        .o_frame_count   (fcnt)
    );

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  l;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  k0;
        logic [1:0]  e_rdy;
        logic [1:0]  e_gnt;
        logic        e_mv;
        logic [31:0] e_md;
        logic [3:0]  e_mk;
        logic        e_ml;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] v, input logic [1:0] l, input logic [31:0] d0,
                                input logic [31:0] d1, input logic [3:0] k0, input logic [1:0] e_rdy,
                                input logic [1:0] e_gnt, input logic e_mv, input logic [31:0] e_md,
                                input logic [3:0] e_mk, input logic e_ml);
        vec_t r;
        r.v = v; r.l = l; r.d0 = d0; r.d1 = d1; r.k0 = k0;
        r.e_rdy = e_rdy; r.e_gnt = e_gnt; r.e_mv = e_mv; r.e_md = e_md; r.e_mk = e_mk; r.e_ml = e_ml;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [3:0] k0);
        s_tvalid = v;
        s_tlast  = l;
        s_tdata  = {d1, d0};
        s_tkeep  = {4'hF, k0};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 4'hF);
        m00_if.tready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_tbl(input string tag);
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].l, tbl[i].d0, tbl[i].d1, tbl[i].k0);
            @(negedge clk);
            chk($sformatf("%s[%0d].tready", tag, i), 32'(s_tready), 32'(tbl[i].e_rdy));
            chk($sformatf("%s[%0d].grant", tag, i), 32'(grant), 32'(tbl[i].e_gnt));
            chk($sformatf("%s[%0d].m_valid", tag, i), 32'(m00_if.tvalid), 32'(tbl[i].e_mv));
            if (tbl[i].e_mv) begin
                chk($sformatf("%s[%0d].m_data", tag, i), m00_if.tdata, tbl[i].e_md);
                chk($sformatf("%s[%0d].m_keep", tag, i), 32'(m00_if.tkeep), 32'(tbl[i].e_mk));
                chk($sformatf("%s[%0d].m_last", tag, i), 32'(m00_if.tlast), 32'(tbl[i].e_ml));
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int          sent;
        int          got;
        logic        stalled;
        logic        src_acc;
        logic [31:0] held_data;
        logic        held_last;

        drive(2'b00, 2'b00, 32'h0, 32'h0, 4'hF);
        m00_if.tready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.grant", 32'(grant), 32'h0);
        chk("rst.m_valid", 32'(m00_if.tvalid), 32'h0);
        chk("rst.m_data", m00_if.tdata, 32'h0);
        chk("rst.tready", 32'(s_tready), 32'h0);
        chk("rst.fcnt", fcnt, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single 4-beat frame from src0
        tbl.delete();
        tbl.push_back(mk(2'b01, 2'b00, 32'h11111111, 32'h0, 4'hF, 2'b00, 2'b00, 1'b0, 32'h0,        4'h0, 1'b0));
        tbl.push_back(mk(2'b01, 2'b00, 32'h11111111, 32'h0, 4'hF, 2'b01, 2'b01, 1'b0, 32'h0,        4'h0, 1'b0));
        tbl.push_back(mk(2'b01, 2'b00, 32'h22222222, 32'h0, 4'hF, 2'b01, 2'b01, 1'b1, 32'h11111111, 4'hF, 1'b0));
        tbl.push_back(mk(2'b01, 2'b00, 32'h33333333, 32'h0, 4'hF, 2'b01, 2'b01, 1'b1, 32'h22222222, 4'hF, 1'b0));
        tbl.push_back(mk(2'b01, 2'b01, 32'h44444444, 32'h0, 4'h3, 2'b01, 2'b01, 1'b1, 32'h33333333, 4'hF, 1'b0));
        tbl.push_back(mk(2'b00, 2'b00, 32'h0,        32'h0, 4'hF, 2'b00, 2'b00, 1'b1, 32'h44444444, 4'h3, 1'b1));
        tbl.push_back(mk(2'b00, 2'b00, 32'h0,        32'h0, 4'hF, 2'b00, 2'b00, 1'b0, 32'h0,        4'h0, 1'b0));
        run_tbl("single");
        chk("single.fcnt0", 32'(fcnt[15:0]), 32'd1);
        chk("single.fcnt1", 32'(fcnt[31:16]), 32'd0);

        // contention: both sources always valid, round-robin starts at src0
        do_reset();
        tbl.delete();
        tbl.push_back(mk(2'b11, 2'b00, 32'hA0000001, 32'hB0000001, 4'hF, 2'b00, 2'b00, 1'b0, 32'h0,        4'h0, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 32'hA0000001, 32'hB0000001, 4'hF, 2'b01, 2'b01, 1'b0, 32'h0,        4'h0, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 32'hA0000002, 32'hB0000001, 4'hF, 2'b01, 2'b01, 1'b1, 32'hA0000001, 4'hF, 1'b0));
        tbl.push_back(mk(2'b11, 2'b01, 32'hA0000003, 32'hB0000001, 4'hF, 2'b01, 2'b01, 1'b1, 32'hA0000002, 4'hF, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 32'hA0000004, 32'hB0000001, 4'hF, 2'b00, 2'b00, 1'b1, 32'hA0000003, 4'hF, 1'b1));
        tbl.push_back(mk(2'b11, 2'b00, 32'hA0000004, 32'hB0000001, 4'hF, 2'b10, 2'b10, 1'b0, 32'h0,        4'h0, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 32'hA0000004, 32'hB0000002, 4'hF, 2'b10, 2'b10, 1'b1, 32'hB0000001, 4'hF, 1'b0));
        tbl.push_back(mk(2'b11, 2'b10, 32'hA0000004, 32'hB0000003, 4'hF, 2'b10, 2'b10, 1'b1, 32'hB0000002, 4'hF, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 32'hA0000004, 32'hB0000004, 4'hF, 2'b00, 2'b00, 1'b1, 32'hB0000003, 4'hF, 1'b1));
        tbl.push_back(mk(2'b11, 2'b00, 32'hA0000004, 32'hB0000004, 4'hF, 2'b01, 2'b01, 1'b0, 32'h0,        4'h0, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 32'hA0000005, 32'hB0000004, 4'hF, 2'b01, 2'b01, 1'b1, 32'hA0000004, 4'hF, 1'b0));
        run_tbl("contend");
        chk("contend.fcnt0", 32'(fcnt[15:0]), 32'd1);
        chk("contend.fcnt1", 32'(fcnt[31:16]), 32'd1);

        // 64-beat frame under random output backpressure
        do_reset();
        sent = 0;
        got = 0;
        stalled = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        for (int cyc = 0; cyc < 2000 && got < 64; cyc++) begin
            m00_if.tready = 1'($urandom_range(0, 1));
            drive({1'b0, sent < 64}, {1'b0, sent == 63}, 32'hC0000000 + 32'(sent), 32'h0, 4'hF);
            @(negedge clk);
            if (stalled) begin
                chk("bp.hold_valid", 32'(m00_if.tvalid), 32'h1);
                chk("bp.hold_data", m00_if.tdata, held_data);
                chk("bp.hold_last", 32'(m00_if.tlast), 32'(held_last));
            end
            if (m00_if.tvalid && m00_if.tready) begin
                chk("bp.beat_data", m00_if.tdata, 32'hC0000000 + 32'(got));
                chk("bp.beat_last", 32'(m00_if.tlast), 32'(got == 63));
                got++;
            end
            stalled   = m00_if.tvalid && !m00_if.tready;
            held_data = m00_if.tdata;
            held_last = m00_if.tlast;
            src_acc   = s_tvalid[0] && s_tready[0];
            @(posedge clk);
            #1;
            if (src_acc) sent++;
        end
        chk("bp.beats_out", 32'(got), 32'd64);
        chk("bp.fcnt0", 32'(fcnt[15:0]), 32'd1);

        // granted src1 goes silent mid-frame while src0 keeps requesting
        do_reset();
        drive(2'b10, 2'b00, 32'h0, 32'hE0000001, 4'hF);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall.grant_first", 32'(grant), 32'h2);
        @(posedge clk);
        #1;
        drive(2'b01, 2'b01, 32'hDEAD0000, 32'hE0000002, 4'hF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall.grant_held", 32'(grant), 32'h2);
            chk("stall.tready", 32'(s_tready), 32'h2);
            chk("stall.no_src0", 32'(m00_if.tvalid && m00_if.tdata == 32'hDEAD0000), 32'h0);
            @(posedge clk);
            #1;
        end
        drive(2'b11, 2'b11, 32'hDEAD0000, 32'hE0000002, 4'hF);
        @(posedge clk);
        #1;
        drive(2'b01, 2'b01, 32'hDEAD0000, 32'h0, 4'hF);
        @(negedge clk);
        chk("stall.grant_released", 32'(grant), 32'h0);
        chk("stall.last_data", m00_if.tdata, 32'hE0000002);
        chk("stall.last_flag", 32'(m00_if.tlast), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall.next_grant", 32'(grant), 32'h1);
        chk("stall.fcnt", fcnt, 32'h0001_0000);

        // reset asserted while beat 2 of a src1 frame is pending
        do_reset();
        drive(2'b01, 2'b01, 32'h77777777, 32'h0, 4'hF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        drive(2'b10, 2'b00, 32'h0, 32'hF0000001, 4'hF);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rmid.grant_pre", 32'(grant), 32'h2);
        @(posedge clk);
        #1;
        drive(2'b10, 2'b00, 32'h0, 32'hF0000002, 4'hF);
        #2 rst_n = 1'b0;
        #1;
        chk("rmid.m_valid", 32'(m00_if.tvalid), 32'h0);
        chk("rmid.m_data", m00_if.tdata, 32'h0);
        chk("rmid.grant", 32'(grant), 32'h0);
        chk("rmid.tready", 32'(s_tready), 32'h0);
        chk("rmid.fcnt", fcnt, 32'h0);
        @(posedge clk);
        #1;
        drive(2'b11, 2'b00, 32'h12340000, 32'hF0000001, 4'hF);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rmid.next_grant", 32'(grant), 32'h1);

        // 65536 one-beat frames on src0 wrap its counter
        do_reset();
        drive(2'b01, 2'b01, 32'h0, 32'h0, 4'hF);
        repeat (2 * 65535) @(posedge clk);
        @(negedge clk);
        chk("wrap.fcnt0_ffff", 32'(fcnt[15:0]), 32'h0000FFFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("wrap.fcnt0_zero", 32'(fcnt[15:0]), 32'h0);
        chk("wrap.fcnt1", 32'(fcnt[31:16]), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
